// File: rtl/x4l_spi_bridge.sv
// Replays queued byte commands as Z80-style I/O cycles into the XERA4Lite SPI controller; read bytes go to a FWFT RX FIFO.
// Command pop to strobe low takes 2 cycles; a READ waits in IDLE while the RX FIFO is full, and CMD_WR is dropped while CMD_FULL is high.
module x4l_spi_bridge_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] dat_i,
    input  logic         pop_i,
    output logic [W-1:0] dat_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         push_ok;
    logic         pop_ok;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    // A pop frees the slot a same-cycle push on a full FIFO needs; a pop on empty never happens.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign dat_o   = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
    assign wptr_d  = push_ok ? wptr_q + PTR_ONE : wptr_q;
    assign rptr_d  = pop_ok ? rptr_q + PTR_ONE : rptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wptr_q[AW-1:0]] <= dat_i;
        end
    end
endmodule

module x4l_spi_bridge #(
    parameter int CMD_DEPTH = 16,
    parameter int RX_DEPTH  = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CMD_WR,
    input  logic [9:0] CMD_DATA,
    output logic       CMD_FULL,
    input  logic       RX_RD,
    output logic [7:0] RX_DATA,
    output logic       RX_EMPTY,
    output logic       BUSY,
    output logic       SPI_nCS,
    output logic       SPI_nRD,
    output logic       SPI_nWR,
    output logic       SPI_ADD,
    output logic [7:0] SPI_DOUT,
    output logic       SPI_DOE,
    input  logic [7:0] SPI_DIN,
    input  logic       SPI_nWAIT
);
    localparam logic [2:0] S_SYNC    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_SETUP   = 3'd2;
    localparam logic [2:0] S_STROBE  = 3'd3;
    localparam logic [2:0] S_XFER    = 3'd4;
    localparam logic [2:0] S_RELEASE = 3'd5;

    logic [2:0] state_q, state_d;
    logic [9:0] cmd_q, cmd_d;
    logic [9:0] cmd_head;
    logic       cmd_empty;
    logic       cmd_pop;
    logic       rx_full;
    logic       rx_push;
    logic       bus_active;
    logic       strobe_active;

    x4l_spi_bridge_fifo #(.DEPTH(CMD_DEPTH), .W(10)) u_cmd_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (CMD_WR),
        .dat_i   (CMD_DATA),
        .pop_i   (cmd_pop),
        .dat_o   (cmd_head),
        .full_o  (CMD_FULL),
        .empty_o (cmd_empty)
    );

    x4l_spi_bridge_fifo #(.DEPTH(RX_DEPTH), .W(8)) u_rx_fifo (
        .clk_i   (CLK),
        .rst_i   (RST),
        .push_i  (rx_push),
        .dat_i   (SPI_DIN),
        .pop_i   (RX_RD),
        .dat_o   (RX_DATA),
        .full_o  (rx_full),
        .empty_o (RX_EMPTY)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cmd_pop = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            S_SYNC: begin
                if (SPI_nWAIT) state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!cmd_empty && !(cmd_head[9] && rx_full)) begin
                    cmd_pop = 1'b1;
                    cmd_d   = cmd_head;
                    state_d = S_SETUP;
                end
            end
            S_SETUP:  state_d = S_STROBE;
            S_STROBE: begin
                if (!SPI_nWAIT) state_d = S_XFER;
            end
            S_XFER: begin
                // nRD is still low here, so SPI_DIN carries the byte just received.
                if (SPI_nWAIT) begin
                    rx_push = cmd_q[9];
                    state_d = S_RELEASE;
                end
            end
            S_RELEASE: state_d = S_IDLE;
            default:   state_d = S_SYNC;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_SYNC;
            cmd_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    assign bus_active    = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_XFER);
    assign strobe_active = (state_q == S_STROBE) || (state_q == S_XFER);

    assign SPI_nCS  = !bus_active;
    assign SPI_nRD  = !(strobe_active && cmd_q[9]);
    assign SPI_nWR  = !(strobe_active && !cmd_q[9]);
    assign SPI_ADD  = bus_active ? cmd_q[8] : 1'b1;
    assign SPI_DOE  = bus_active && !cmd_q[9];
    assign SPI_DOUT = SPI_DOE ? cmd_q[7:0] : 8'h00;
    assign BUSY     = (state_q != S_IDLE) || !cmd_empty;
endmodule

// File: tb/tb_x4l_spi_bridge.sv
// Directed bench with a negedge SPI controller model and scoreboards for bus cycles and read data.
module tb_x4l_spi_bridge;
    localparam int SEL_NCS   = 0;
    localparam int SEL_NWAIT = 1;
    localparam int SEL_BUSY  = 2;
    localparam int SEL_RXE   = 3;
    localparam int SEL_NRD   = 4;
    localparam int BOUND     = 3000;
    localparam logic [23:0] RST_VEC = {8'b1111_0011, 8'h00, 8'h00};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CMD_WR = 1'b0;
    logic [9:0] CMD_DATA = 10'h000;
    logic       RX_RD = 1'b0;
    logic       CMD_FULL, RX_EMPTY, BUSY;
    logic [7:0] RX_DATA, SPI_DOUT;
    logic       SPI_nCS, SPI_nRD, SPI_nWR, SPI_ADD, SPI_DOE;
    logic [7:0] SPI_DIN = 8'h00;
    logic       SPI_nWAIT = 1'b0;

    int checks = 0;
    int errors = 0;
    logic hold_low = 1'b1;
    int  wait_cnt = 0;
    logic wait_dly = 1'b0;
    logic strobe_prev = 1'b0;
    int  nbus = 0;
    int  ncs_in_hold = 0;
    logic [10:0] exp_bus[$];
    logic [7:0]  slave_q[$];
    logic [7:0]  rx_exp[$];

    always #5 CLK = ~CLK;

    x4l_spi_bridge dut (
        .CLK(CLK), .RST(RST), .CMD_WR(CMD_WR), .CMD_DATA(CMD_DATA), .CMD_FULL(CMD_FULL),
        .RX_RD(RX_RD), .RX_DATA(RX_DATA), .RX_EMPTY(RX_EMPTY), .BUSY(BUSY),
        .SPI_nCS(SPI_nCS), .SPI_nRD(SPI_nRD), .SPI_nWR(SPI_nWR), .SPI_ADD(SPI_ADD),
        .SPI_DOUT(SPI_DOUT), .SPI_DOE(SPI_DOE), .SPI_DIN(SPI_DIN), .SPI_nWAIT(SPI_nWAIT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [10:0] bus_expect(input logic [9:0] c);
        return c[9] ? {1'b1, c[8], 1'b0, 8'h00} : {1'b0, c[8], 1'b1, c[7:0]};
    endfunction

    function automatic logic [23:0] out_vec();
        return {SPI_nCS, SPI_nRD, SPI_nWR, SPI_ADD, SPI_DOE, CMD_FULL, RX_EMPTY, BUSY, SPI_DOUT, RX_DATA};
    endfunction

    function automatic logic pick(input int sel);
        case (sel)
            SEL_NCS:   return SPI_nCS;
            SEL_NWAIT: return SPI_nWAIT;
            SEL_BUSY:  return BUSY;
            SEL_RXE:   return RX_EMPTY;
            default:   return SPI_nRD;
        endcase
    endfunction

    task automatic wait_until(input int sel, input logic val, input string tag);
        int n = 0;
        while (pick(sel) !== val && n < BOUND) begin
            step();
            n++;
        end
        check(tag, {31'd0, n < BOUND}, 32'd1);
    endtask

    task automatic push(input logic [9:0] c, input logic accept);
        CMD_WR   = 1'b1;
        CMD_DATA = c;
        if (accept) exp_bus.push_back(bus_expect(c));
        step();
        CMD_WR = 1'b0;
    endtask

    task automatic pop_rx();
        RX_RD = 1'b1;
        step();
        RX_RD = 1'b0;
    endtask

    // Controller model: nWAIT falls one cycle after a strobe edge and stays low 18 cycles.
    initial begin
        logic strobe;
        logic [10:0] seen;
        logic [10:0] want;
        forever begin
            @(negedge CLK);
            if (hold_low) begin
                SPI_nWAIT = 1'b0;
                wait_dly  = 1'b0;
                wait_cnt  = 0;
                if (!SPI_nCS) ncs_in_hold++;
            end else if (wait_dly) begin
                wait_dly  = 1'b0;
                SPI_nWAIT = 1'b0;
                wait_cnt  = 18;
            end else if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) SPI_nWAIT = 1'b1;
            end else begin
                SPI_nWAIT = 1'b1;
            end
            strobe = !SPI_nCS && (!SPI_nRD || !SPI_nWR);
            if (strobe && !strobe_prev) begin
                wait_dly = 1'b1;
                nbus++;
                seen = {!SPI_nRD, SPI_ADD, SPI_DOE, SPI_nRD ? SPI_DOUT : 8'h00};
                if (!SPI_nRD) SPI_DIN = (slave_q.size() > 0) ? slave_q.pop_front() : 8'hEE;
                want = (exp_bus.size() > 0) ? exp_bus.pop_front() : 11'h7FF;
                check("bus_cycle", {21'd0, seen}, {21'd0, want});
            end
            strobe_prev = strobe;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int viol;
        int n;
        int nbus0;
        logic [7:0] b;

        step();
        step();
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_vec", {8'd0, out_vec()}, {8'd0, RST_VEC});
        end
        hold_low = 1'b0;
        wait_until(SEL_BUSY, 1'b0, "sync_exit");

        push(10'h0A5, 1'b1);
        check("wr_c1_ncs", {31'd0, SPI_nCS}, 32'd1);
        step();
        check("wr_c2_setup", {20'd0, SPI_nCS, SPI_nWR, SPI_DOE, SPI_ADD, SPI_DOUT}, {20'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hA5});
        step();
        check("wr_c3_strobe", {20'd0, SPI_nCS, SPI_nWR, SPI_nRD, SPI_DOE, SPI_DOUT}, {20'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5});
        wait_until(SEL_NWAIT, 1'b0, "wr_wait_lo");
        wait_until(SEL_NWAIT, 1'b1, "wr_wait_hi");
        check("wr_release", {29'd0, SPI_nCS, SPI_nWR, SPI_DOE}, {29'd0, 3'b110});
        check("wr_rx_empty", {31'd0, RX_EMPTY}, 32'd1);
        wait_until(SEL_BUSY, 1'b0, "wr_done");

        slave_q.push_back(8'h3C);
        rx_exp.push_back(8'h3C);
        push(10'h300, 1'b1);
        wait_until(SEL_NRD, 1'b0, "rd_strobe");
        check("rd_add", {29'd0, SPI_ADD, SPI_nCS, SPI_DOE}, {29'd0, 3'b100});
        wait_until(SEL_NWAIT, 1'b0, "rd_wait_lo");
        wait_until(SEL_NWAIT, 1'b1, "rd_wait_hi");
        check("rd_rx_timing", {29'd0, RX_EMPTY, SPI_nRD, SPI_nCS}, {29'd0, 3'b011});
        check("rd_data", {24'd0, RX_DATA}, {24'd0, rx_exp.pop_front()});
        pop_rx();
        check("rd_rx_popped", {31'd0, RX_EMPTY}, 32'd1);
        wait_until(SEL_BUSY, 1'b0, "rd_done");

        hold_low = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        nbus0 = nbus;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 17 + 3);
            push({1'b0, b[0], b}, 1'b1);
        end
        check("stall_full", {31'd0, CMD_FULL}, 32'd1);
        push(10'h0FF, 1'b0);
        check("stall_drop", {30'd0, CMD_FULL, SPI_nCS}, {30'd0, 2'b11});
        hold_low = 1'b0;
        wait_until(SEL_BUSY, 1'b0, "stall_drain");
        check("stall_nbus", nbus - nbus0, 32'd16);
        check("stall_sb_empty", exp_bus.size(), 32'd0);

        for (int i = 0; i < 16; i++) begin
            b = 8'h40 + 8'(i);
            slave_q.push_back(b);
            rx_exp.push_back(b);
            push({1'b1, b[1], 8'h5A}, 1'b1);
        end
        wait_until(SEL_BUSY, 1'b0, "rx_fill");
        check("rx_fill_nonempty", {31'd0, RX_EMPTY}, 32'd0);
        slave_q.push_back(8'h99);
        rx_exp.push_back(8'h99);
        push(10'h3AA, 1'b1);
        viol = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!SPI_nCS) viol++;
        end
        check("rx_full_ncs", viol, 32'd0);
        check("rx_full_busy", {31'd0, BUSY}, 32'd1);
        check("rx_head", {24'd0, RX_DATA}, {24'd0, rx_exp.pop_front()});
        pop_rx();
        wait_until(SEL_BUSY, 1'b0, "rx_17th");
        for (int i = 0; i < 16; i++) begin
            check("rx_drain", {24'd0, RX_DATA}, {24'd0, rx_exp.pop_front()});
            pop_rx();
        end
        check("rx_drained", {31'd0, RX_EMPTY}, 32'd1);

        slave_q.push_back(8'h5A);
        push(10'h200, 1'b1);
        wait_until(SEL_RXE, 1'b0, "rst_pre_rd");
        push(10'h0C3, 1'b1);
        push(10'h0D4, 1'b1);
        wait_until(SEL_NWAIT, 1'b0, "rst_in_xfer");
        check("rst_pre_state", {30'd0, SPI_nCS, SPI_nWR}, {30'd0, 2'b00});
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("rst_mid_xfer", {27'd0, SPI_nCS, SPI_nRD, SPI_nWR, RX_EMPTY, BUSY}, {27'd0, 5'b11111});
        exp_bus.delete();
        nbus0 = nbus;
        push(10'h0E7, 1'b1);
        viol = 0;
        n = 0;
        while (SPI_nWAIT === 1'b0 && n < 100) begin
            if (!SPI_nCS) viol++;
            step();
            n++;
        end
        check("rst_wait_seen", {31'd0, n > 0}, 32'd1);
        check("rst_wait_bound", {31'd0, n < 100}, 32'd1);
        check("rst_sync_ncs", viol, 32'd0);
        wait_until(SEL_BUSY, 1'b0, "rst_e7_done");
        check("rst_nbus", nbus - nbus0, 32'd1);
        check("rst_sb_empty", exp_bus.size(), 32'd0);
        check("rst_rx_empty", {31'd0, RX_EMPTY}, 32'd1);
        check("hold_ncs", ncs_in_hold, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
